// File: rtl/nibble_debounce_sync.sv
// Input conditioning for the raw switch nibble: two-flop synchroniser, per-bit debounce,
// registered edge pulses and a wrapping count of accepted transitions.
module nibble_debounce_sync #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned EVT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic [EVT_W-1:0] event_cnt
);

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            db_q, db_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic                        changed_q, changed_d;
  logic [EVT_W-1:0]            event_q, event_d;
  logic [EVT_W-1:0]            evt_add;

  // Synchroniser free-runs so the sampled level is current when ena returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = '0;
    fall_d  = '0;
    evt_add = '0;
    if (ena) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2_q[i] == db_q[i]) begin
          // Any agreeing sample discards progress towards a new level.
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DbLast) begin
          db_d[i]   = sync2_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      evt_add = evt_add + EVT_W'(rise_d[i] | fall_d[i]);
    end
    changed_d = |(rise_d | fall_d);
    event_d   = event_q + evt_add;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      db_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      event_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      event_q   <= event_d;
    end
  end

  assign db_out    = db_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign changed   = changed_q;
  assign event_cnt = event_q;

endmodule

// File: tb/tb_nibble_debounce_sync.sv
// Directed bench for nibble_debounce_sync: vector table for latency/enable behaviour,
// plus hand-written bounce, asynchronous reset and event-counter wrap sequences.
module tb_nibble_debounce_sync;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] din;
  logic [3:0] db_out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       changed;
  logic [7:0] event_cnt;

  int n_pass  = 0;
  int n_total = 0;

  nibble_debounce_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .din       (din),
    .db_out    (db_out),
    .rise      (rise),
    .fall      (fall),
    .changed   (changed),
    .event_cnt (event_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    logic       ena;
    int         n;
    logic [3:0] exp_db;
    logic [3:0] exp_rise;
    logic [3:0] exp_fall;
    logic       exp_ch;
    logic [7:0] exp_ev;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_all(input string tag, input logic [3:0] db, input logic [3:0] r,
                           input logic [3:0] f, input logic ch, input logic [7:0] ev);
    check({tag, ".db_out"}, 32'(db_out), 32'(db));
    check({tag, ".rise"}, 32'(rise), 32'(r));
    check({tag, ".fall"}, 32'(fall), 32'(f));
    check({tag, ".changed"}, 32'(changed), 32'(ch));
    check({tag, ".event_cnt"}, 32'(event_cnt), 32'(ev));
  endtask

  initial begin
    vec_t vecs[11];
    int   bad;
    int   rise_cnt;
    int   ch_cnt;

    // Edge counts are cumulative from reset release; din changes just after an edge.
    vecs[0]  = '{4'hF, 1'b1, 17, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0};  // edges 1..17
    vecs[1]  = '{4'hF, 1'b1, 1,  4'hF, 4'hF, 4'h0, 1'b1, 8'd4};  // edge 18 accept
    vecs[2]  = '{4'hF, 1'b1, 1,  4'hF, 4'h0, 4'h0, 1'b0, 8'd4};  // pulse is one cycle
    vecs[3]  = '{4'h0, 1'b1, 17, 4'hF, 4'h0, 4'h0, 1'b0, 8'd4};
    vecs[4]  = '{4'h0, 1'b1, 1,  4'h0, 4'h0, 4'hF, 1'b1, 8'd8};
    vecs[5]  = '{4'h0, 1'b1, 1,  4'h0, 4'h0, 4'h0, 1'b0, 8'd8};
    vecs[6]  = '{4'h4, 1'b1, 5,  4'h0, 4'h0, 4'h0, 1'b0, 8'd8};  // cnt[2] = 3
    vecs[7]  = '{4'h4, 1'b0, 10, 4'h0, 4'h0, 4'h0, 1'b0, 8'd8};  // held
    vecs[8]  = '{4'h4, 1'b1, 12, 4'h0, 4'h0, 4'h0, 1'b0, 8'd8};  // edges 16..27
    vecs[9]  = '{4'h4, 1'b1, 1,  4'h4, 4'h4, 4'h0, 1'b1, 8'd9};  // edge 28
    vecs[10] = '{4'h4, 1'b1, 1,  4'h4, 4'h0, 4'h0, 1'b0, 8'd9};

    rst_n = 1'b0;
    ena   = 1'b1;
    din   = 4'hF;
    #12;
    check_all("reset", 4'h0, 4'h0, 4'h0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      din = vecs[v].din;
      ena = vecs[v].ena;
      tick(vecs[v].n);
      check_all($sformatf("vec%0d", v), vecs[v].exp_db, vecs[v].exp_rise, vecs[v].exp_fall,
                vecs[v].exp_ch, vecs[v].exp_ev);
    end

    // Bounce on bit 0: 5-cycle segments never reach the 16-sample threshold.
    bad      = 0;
    rise_cnt = 0;
    for (int s = 0; s < 12; s++) begin
      din = {3'b010, (s % 2 == 0)};
      for (int k = 0; k < 5; k++) begin
        tick(1);
        if (db_out[0] !== 1'b0) bad++;
        rise_cnt += int'(rise[0]);
      end
    end
    check("bounce.db_held", 32'(bad), 32'd0);
    din = 4'h5;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      rise_cnt += int'(rise[0]);
      if (k == 17) check("bounce.db_edge17", 32'(db_out), 32'h4);
      if (k == 18) begin
        check("bounce.db_edge18", 32'(db_out), 32'h5);
        check("bounce.rise_edge18", 32'(rise), 32'h1);
      end
    end
    tick(1);
    rise_cnt += int'(rise[0]);
    check("bounce.rise_pulses", 32'(rise_cnt), 32'd1);
    check("bounce.event_cnt", 32'(event_cnt), 32'd10);

    // Async reset while cnt[1] = 10, then full re-acceptance latency.
    din = 4'h7;
    tick(12);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 4'h0, 4'h0, 4'h0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(17);
    check("rst_release.db_edge17", 32'(db_out), 32'h0);
    tick(1);
    check_all("rst_release.edge18", 4'h7, 4'h7, 4'h0, 1'b1, 8'd3);

    // Clean start for the wrap test.
    din   = 4'h0;
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    ch_cnt = 0;
    for (int p = 0; p < 128; p++) begin
      din = (p % 2 == 0) ? 4'hF : 4'h0;
      for (int k = 0; k < 18; k++) begin
        tick(1);
        ch_cnt += int'(changed);
      end
      if (p == 0) check("wrap.after_first", 32'(event_cnt), 32'd4);
      if (p == 62) check("wrap.before_wrap", 32'(event_cnt), 32'd252);
      if (p == 63) check("wrap.at_256", 32'(event_cnt), 32'd0);
    end
    check("wrap.final_event_cnt", 32'(event_cnt), 32'd0);
    check("wrap.changed_pulses", 32'(ch_cnt), 32'd128);
    check("wrap.final_db", 32'(db_out), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nibble_debounce_sync.md
Name: nibble_debounce_sync

Overview:
- Input-conditioning stage that sits directly upstream of the nibble inverter stage.
- Takes the raw switch/button nibble from the dedicated inputs and passes it through a two-flop synchroniser, then a per-bit debounce counter.
- Outputs a clean, stable nibble for the inverter, plus per-bit rise and fall pulses and a wrapping count of debounced transitions, for status and display use.

Parameters:
- WIDTH, 4: number of input bits conditioned.
- DB_CYCLES, 16: consecutive synchronised cycles a new level must persist before it is accepted; legal range 1..2^CNT_W-1.
- CNT_W, 5: width of each per-bit debounce counter.
- EVT_W, 8: width of the transition event counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  design enable; high means run, low means hold.
- din  input  WIDTH  raw asynchronous inputs, driven from ui_in[3:0].
- db_out  output  WIDTH  debounced level; feeds the inverter stage.
- rise  output  WIDTH  one-cycle pulse when a db_out bit goes 0 to 1.
- fall  output  WIDTH  one-cycle pulse when a db_out bit goes 1 to 0.
- changed  output  1  OR of all rise and fall bits, same cycle.
- event_cnt  output  EVT_W  running count of accepted bit transitions.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst_n is asynchronous, active-low. Assertion takes effect immediately; release is sampled on clk.
- Reset values (all registers):
  - sync1 = sync2 = 0.
  - All counters = 0.
  - db_out = 0, rise = 0, fall = 0, changed = 0, event_cnt = 0.
- Synchroniser:
  - sync1 <= din, then sync2 <= sync1, every cycle.
  - It runs regardless of ena.
  - Only sync2 is used downstream; din is never used combinationally.
- Per-bit debounce, bit i, evaluated only when ena = 1:
  - If sync2[i] == db_out[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_CYCLES-1: db_out[i] <= sync2[i], cnt[i] <= 0, and the matching rise[i] or fall[i] = 1 for the next cycle only.
  - Else: cnt[i] <= cnt[i]+1.
- Bounce handling:
  - Any single sample of sync2[i] equal to db_out[i] restarts that bit's count from 0.
  - No partial credit carries over.
- Latency:
  - A clean step on din[i] changes db_out[i] on the (DB_CYCLES+2)th rising clk edge, counting the first edge at which din is sampled new.
  - Default: 18 edges.
  - rise[i]/fall[i] assert in the same cycle db_out[i] changes and are high for exactly one cycle.
- Outputs:
  - All outputs are registered; no combinational path from din.
  - changed = |(rise | fall), registered with them.
- event_cnt:
  - Each accepting cycle, event_cnt <= event_cnt + popcount(rise_next | fall_next), i.e. 0..WIDTH added per cycle.
  - Wraps modulo 2^EVT_W; no saturation.
- ena = 0:
  - Counters, db_out and event_cnt hold their values.
  - rise, fall and changed are forced to 0.
  - When ena returns to 1, counting resumes from the held cnt values.
- Simultaneous events:
  - Bits are fully independent.
  - Several bits may be accepted in the same cycle; each gets its own pulse and all are counted.
- Reset mid-debounce:
  - Partial counts are discarded.
  - After release, an input held at 1 is re-accepted after the full latency.

Test Plan:
- Reset with din = 4'hF held, rst_n released at cycle 0, ena = 1 -> db_out = 0 until edge 18; then db_out = 4'hF, rise = 4'hF for one cycle, changed = 1, event_cnt = 4.
- din[0] toggles every 5 cycles for 60 cycles (bounce), then holds 1 -> db_out[0] stays 0 throughout the bounce; it rises exactly 18 edges after the final 0 to 1 step, with a single rise[0] pulse.
- db_out = 4'hF, then din = 4'h0 clean step -> fall = 4'hF for one cycle on edge 18, rise = 0, event_cnt advances by 4.
- Clean step on din[2] with ena dropped to 0 for 10 cycles mid-count -> db_out[2] changes at edge 28, not 18; rise/fall stay 0 while ena = 0.
- 64 clean toggle pairs on all four bits (512 transitions) -> event_cnt wraps to 0; changed pulses exactly 128 times.
- Assert rst_n asynchronously, mid-cycle, while cnt[1] = 10 -> all outputs read 0 before the next clk edge; after release, bit 1 needs the full 18 edges again.
